// File: rtl/fp_div.sv
// fp_div: iterative floating-point divider, odata = idataA / idataB.
// Restoring radix-2 mantissa divide, one quotient bit per clock, with a
// valid/ready handshake on both sides. Only one operation is in flight.
// Optional build macro FP_DIV_ROUND_EN: adds a guard quotient bit and
// round-to-nearest-even; without it the mantissa is truncated.
//
// state  | meaning
// IDLE   | in_ready high, waiting for operands
// DIVIDE | one quotient bit per cycle, NQ cycles
// NORM   | exponent/mantissa normalisation and special cases
// DONE   | out_valid high, odata held until out_ready

module fp_div #(
    parameter int I_EXP  = 8,
    parameter int I_MNT  = 23,
    parameter int I_DATA = I_EXP + I_MNT + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [I_DATA-1:0] idataA,
    input  logic [I_DATA-1:0] idataB,
    output logic [I_DATA-1:0] odata,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int EXP_BASE = 2**(I_EXP-1) - 1;
`ifdef FP_DIV_ROUND_EN
    localparam int NQ = I_MNT + 3;
`else
    localparam int NQ = I_MNT + 2;
`endif
    localparam int CW = $clog2(NQ);
    localparam int EW = I_EXP + 2;
    localparam int RW = I_MNT + 2;

    localparam logic signed [EW-1:0] BIAS    = EW'(EXP_BASE);
    localparam logic signed [EW-1:0] EXP_MAX = EW'(2**I_EXP - 1);
    localparam logic signed [EW-1:0] E_ONE   = EW'(1);

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

    state_t            state;
    logic              sign_q;
    logic [I_EXP-1:0]  exp_a;
    logic [I_EXP-1:0]  exp_b;
    logic [I_MNT:0]    mnt_b;
    logic [RW-1:0]     rem;
    logic [NQ-1:0]     quo;
    logic [CW-1:0]     cnt;

    logic              rem_ge;
    logic [RW-1:0]     rem_diff;
    logic [RW-1:0]     rem_next;
    logic              q_int;
    logic signed [EW-1:0] e_dec;
    logic signed [EW-1:0] e_calc;
    logic signed [EW-1:0] e_fin;
    logic [I_MNT-1:0]  mnt_fin;
    logic [I_DATA-1:0] norm_word;

    // One restoring-division step: subtract the divisor when it fits, then shift.
    always_comb begin
        rem_ge   = (rem >= {1'b0, mnt_b});
        rem_diff = rem_ge ? (rem - {1'b0, mnt_b}) : rem;
        rem_next = {rem_diff[RW-2:0], 1'b0};
    end

`ifdef FP_DIV_ROUND_EN
    logic [I_MNT-1:0] mnt_t;
    logic             guard_b;
    logic             sticky_b;
    logic             rnd_up;
    logic [I_MNT:0]   mnt_sum;
`endif

    // Normalise the quotient, apply rounding if built in, resolve special cases.
    always_comb begin
        q_int  = quo[NQ-1];
        e_dec  = q_int ? EW'(0) : EW'(1);
        e_calc = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS - e_dec;
`ifdef FP_DIV_ROUND_EN
        mnt_t    = q_int ? quo[NQ-2:2] : quo[NQ-3:1];
        guard_b  = q_int ? quo[1] : quo[0];
        sticky_b = (q_int & quo[0]) | (|rem);
        rnd_up   = guard_b & (sticky_b | mnt_t[0]);
        mnt_sum  = {1'b0, mnt_t} + {{I_MNT{1'b0}}, rnd_up};
        mnt_fin  = mnt_sum[I_MNT-1:0];
        e_fin    = e_calc + (mnt_sum[I_MNT] ? E_ONE : EW'(0));
`else
        mnt_fin  = q_int ? quo[NQ-2:1] : quo[NQ-3:0];
        e_fin    = e_calc;
`endif
        if (exp_a == '0)
            norm_word = '0;
        else if (exp_b == '0)
            norm_word = {sign_q, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
        else if (e_fin < E_ONE)
            norm_word = '0;
        else if (e_fin >= EXP_MAX)
            norm_word = {sign_q, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
        else
            norm_word = {sign_q, e_fin[I_EXP-1:0], mnt_fin};
    end

    // Control FSM and datapath registers; enable low freezes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            odata     <= '0;
            sign_q    <= 1'b0;
            exp_a     <= '0;
            exp_b     <= '0;
            mnt_b     <= '0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= idataA[I_DATA-1] ^ idataB[I_DATA-1];
                        exp_a    <= idataA[I_DATA-2:I_MNT];
                        exp_b    <= idataB[I_DATA-2:I_MNT];
                        mnt_b    <= {1'b1, idataB[I_MNT-1:0]};
                        rem      <= {1'b0, 1'b1, idataA[I_MNT-1:0]};
                        quo      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    quo <= {quo[NQ-2:0], rem_ge};
                    rem <= rem_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NQ-1))
                        state <= NORM;
                end
                NORM: begin
                    odata     <= norm_word;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
